// File: rtl/wait_state_memory.sv
// Single-port RAM with req/ack handshake and a fixed number of programmable wait states.
// Optional write-protected window at the top of memory: define WAIT_STATE_MEMORY_ROM_PROTECT_EN.
`timescale 1ns/1ps

module wait_state_memory #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    WAIT_STATES = 0,
    parameter int unsigned           ROM_BASE    = 32'h0000_ff00,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE  = {DATA_WIDTH{1'b1}},
    parameter string                 INIT_FILE   = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  write_fault
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WS_COUNT = 4'(WAIT_STATES);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("wait_state_memory: WAIT_STATES must be in 0..15");
    end
    if (ROM_BASE > DEPTH - 1) begin : g_bad_rom_base
        $error("wait_state_memory: ROM_BASE lies outside the address space");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              count_reg, count_next;
    logic                    wr_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [DATA_WIDTH-1:0]   data_out_reg;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    commit;
    logic                    op_wr;
    logic [ADDR_WIDTH-1:0]   op_addr;
    logic [DATA_WIDTH-1:0]   op_data;
    logic                    op_fault;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] = FILL_VALUE;
        end
    end

    // With no wait states the commit edge is also the accept edge, so the live inputs are used.
    assign op_wr   = (state_reg == ST_IDLE) ? write_en : wr_reg;
    assign op_addr = (state_reg == ST_IDLE) ? address  : addr_reg;
    assign op_data = (state_reg == ST_IDLE) ? data_in  : data_reg;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        commit     = 1'b0;
        ready      = 1'b0;
        ack        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    count_next = WS_COUNT;
                    if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_DONE;
                        commit     = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next = ST_DONE;
                    commit     = 1'b1;
                end
            end
            ST_DONE: begin
                ack        = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (state_reg == ST_IDLE && req) begin
            wr_reg   <= write_en;
            addr_reg <= address;
            data_reg <= data_in;
        end
    end

    // Reset wins over a commit on the same edge, so an aborted write never lands.
    always_ff @(posedge clock) begin
        if (!reset && commit && op_wr && !op_fault) begin
            mem[op_addr] <= op_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_reg <= '0;
        end else if (commit && !op_wr) begin
            data_out_reg <= mem[op_addr];
        end
    end

    assign data_out = data_out_reg;

`ifdef WAIT_STATE_MEMORY_ROM_PROTECT_EN
    logic fault_reg;

    assign op_fault = op_wr && (op_addr >= ROM_BASE[ADDR_WIDTH-1:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= commit && op_fault;
        end
    end

    assign write_fault = fault_reg;
`else
    assign op_fault    = 1'b0;
    assign write_fault = 1'b0;
`endif

endmodule
